// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the two-input round-robin stream multiplexer.
//   DEFAULT_WIDTH : default payload width of both inputs and the output
//   SRC_I0/SRC_I1 : encoding of the source tag carried on out_src
//   state_e       : occupancy of the one-entry output register
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mux2_rr_arb_if.sv
// ---------------------------------------------------------------------------
// mux2_rr_arb_if
// Bundles the two input streams and the output stream of mux2_rr_arb.
//   i0_valid/i0_data/i0_ready : input stream 0 (valid/ready handshake)
//   i1_valid/i1_data/i1_ready : input stream 1 (valid/ready handshake)
//   out_valid/out_data/out_src/out_ready : registered output stream
// Modports:
//   master : the environment that feeds the inputs and consumes the output
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mux2_rr_arb_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             i0_valid;
  logic [WIDTH-1:0] i0_data;
  logic             i0_ready;

  logic             i1_valid;
  logic [WIDTH-1:0] i1_data;
  logic             i1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport master (
    output i0_valid, i0_data,
    input  i0_ready,
    output i1_valid, i1_data,
    input  i1_ready,
    input  out_valid, out_data, out_src,
    output out_ready
  );

  modport slave (
    input  i0_valid, i0_data,
    output i0_ready,
    input  i1_valid, i1_data,
    output i1_ready,
    output out_valid, out_data, out_src,
    input  out_ready
  );

endinterface

// File: rtl/mux2_1.sv
// ---------------------------------------------------------------------------
// mux2_1
// Single-bit two-to-one multiplexer.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : selected bit
// ---------------------------------------------------------------------------
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_rr_arb.sv
// ---------------------------------------------------------------------------
// mux2_rr_arb
// Merges two valid/ready input streams into one registered output stream.
// When both inputs offer a word, the stream that did not win the previous
// load is granted (round robin); a lone valid input is always granted.
// The output is a single register that can drain and reload on the same
// edge, so a continuously ready consumer sees one word per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : stream bundle (slave side), see mux2_rr_arb_if
// ---------------------------------------------------------------------------
module mux2_rr_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_rr_arb_if.slave   bus
);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             src_q,     src_d;
  logic             lastSrc_q, lastSrc_d;

  logic             loadOk;
  logic             hasGrant;
  logic             grant;
  logic             doLoad;
  logic [WIDTH-1:0] selData;

  // Arbitration: the output register can accept a word when it is empty or
  // is being drained this cycle. With both inputs valid, the stream that did
  // not win the last load is granted; otherwise whichever one is valid.
  always_comb begin
    loadOk   = (state_q == EMPTY) || bus.out_ready;
    hasGrant = bus.i0_valid || bus.i1_valid;
    grant    = SRC_I0;
    if (bus.i0_valid && bus.i1_valid) begin
      grant = ~lastSrc_q;
    end else if (bus.i1_valid) begin
      grant = SRC_I1;
    end
    doLoad = loadOk && hasGrant;
  end

  // Readys are qualified by rst_n so that neither input sees a handshake
  // while reset is held, even though the register reads EMPTY then.
  assign bus.i0_ready = rst_n && doLoad && (grant == SRC_I0);
  assign bus.i1_ready = rst_n && doLoad && (grant == SRC_I1);

  // Per-bit datapath select, steered by the grant.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gSel
    mux2_1 uMux (
      .a (bus.i0_data[gi]),
      .b (bus.i1_data[gi]),
      .s (grant),
      .y (selData[gi])
    );
  end

  // Next-state for the output register: a load captures the granted word
  // and its source; a drain with nothing to reload just empties the slot and
  // leaves the data untouched. last_src only moves on a load.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    src_d     = src_q;
    lastSrc_d = lastSrc_q;
    if (doLoad) begin
      state_d   = FULL;
      data_d    = selData;
      src_d     = grant;
      lastSrc_d = grant;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register and round-robin pointer. Reset leaves last_src pointing
  // at stream 1 so that stream 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      src_q     <= SRC_I0;
      lastSrc_q <= SRC_I1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      src_q     <= src_d;
      lastSrc_q <= lastSrc_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux2_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arb
// Directed bench for mux2_rr_arb: reset behaviour, round-robin alternation,
// single-stream streaming, stall/drain/reload, asynchronous reset while
// full, and a valid pulse that is never granted.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arb;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;

  mux2_rr_arb_if #(.WIDTH(8)) bus ();

  mux2_rr_arb #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all stream inputs at once.
  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               input logic oRdy);
    bus.i0_valid  = v0;
    bus.i0_data   = d0;
    bus.i1_valid  = v1;
    bus.i1_data   = d1;
    bus.out_ready = oRdy;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReadys(input string tag, input logic r0, input logic r1);
    checkOutput({tag, ".i0_ready"}, {31'd0, bus.i0_ready}, {31'd0, r0});
    checkOutput({tag, ".i1_ready"}, {31'd0, bus.i1_ready}, {31'd0, r1});
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [7:0] d,
                          input logic s);
    checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    checkOutput({tag, ".out_data"},  {24'd0, bus.out_data},  {24'd0, d});
    checkOutput({tag, ".out_src"},   {31'd0, bus.out_src},   {31'd0, s});
  endtask

  // One clock cycle: drive after the falling edge, check readys before the
  // rising edge, then check the registered output just after it.
  task automatic cycle(input string tag,
                       input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic oRdy,
                       input logic r0, input logic r1,
                       input logic eV, input logic [7:0] eD, input logic eS);
    @(negedge clk);
    applyStimulus(v0, d0, v1, d1, oRdy);
    #1;
    checkReadys(tag, r0, r1);
    @(posedge clk);
    #1;
    checkOut(tag, eV, eD, eS);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;

    // Scenario 1: reset held with both inputs valid.
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checkReadys("rst_hold", 1'b0, 1'b0);
    checkOut("rst_hold", 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    cycle("s1_first", 1, 8'hA0, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 0);

    // Scenario 2: both valid, alternation.
    cycle("s2_c1", 1, 8'hA0, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1);
    cycle("s2_c2", 1, 8'hA0, 1, 8'hB1, 1, 1, 0, 1, 8'hA0, 0);
    cycle("s2_c3", 1, 8'hA0, 1, 8'hB1, 1, 0, 1, 1, 8'hB1, 1);

    // Scenario 3: stream 1 alone, granted every cycle.
    for (int k = 0; k < 4; k++) begin
      cycle($sformatf("s3_c%0d", k), 0, 8'h00, 1, 8'h10 + 8'(k), 1,
            0, 1, 1, 8'h10 + 8'(k), 1);
    end
    // Idle inputs: drain to empty, data kept.
    cycle("s3_drain", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h13, 1);

    // Scenario 4: load 5C, stall three cycles, then drain and reload.
    cycle("s4_load", 1, 8'h5C, 0, 8'h00, 0, 1, 0, 1, 8'h5C, 0);
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("s4_stall%0d", k), 1, 8'h77, 1, 8'h88, 0,
            0, 0, 1, 8'h5C, 0);
    end
    cycle("s4_reload", 1, 8'h77, 1, 8'h88, 1, 0, 1, 1, 8'h88, 1);

    // Scenario 6: stream 0 pulses while stalled; its word is never taken.
    cycle("s6_pulse", 1, 8'hEE, 0, 8'h00, 0, 0, 0, 1, 8'h88, 1);
    cycle("s6_drain", 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h88, 1);

    // Scenario 5: load from stream 0, then pulse reset between edges.
    cycle("s5_load", 1, 8'h42, 0, 8'h00, 0, 1, 0, 1, 8'h42, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOut("s5_async", 1'b0, 8'h00, 1'b0);
    checkReadys("s5_async", 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h61, 1'b1, 8'h62, 1'b1);
    #1;
    checkReadys("s5_contend", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOut("s5_contend", 1'b1, 8'h61, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
